// File: rtl/dram_frame_streamer_if.sv
// RAM read port and uart_tx handshake bundle for dram_frame_streamer.
// master = streamer side, slave = RAM/UART side.
interface dram_frame_streamer_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_q;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_done;

  modport master (
    output ram_addr, tx_dv, tx_byte,
    input  ram_q, tx_done
  );

  modport slave (
    input  ram_addr, tx_dv, tx_byte,
    output ram_q, tx_done
  );
endinterface

// File: rtl/dram_frame_streamer.sv
// Streams an inclusive RAM address range byte by byte into uart_tx.
// Define STREAM_CHECKSUM_EN to append an 8-bit sum byte to each transfer.
module dram_frame_streamer #(
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  dram_frame_streamer_if.master bus,
  output logic              busy,
  output logic              fin,
  output logic [ADDR_W:0]   byte_count
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, SEND, WAIT_DONE, ADVANCE, DONE
  } state_t;

`ifdef STREAM_CHECKSUM_EN
  localparam state_t TAIL = SEND;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t            state, nxt;
  logic [ADDR_W-1:0] addr_q, end_q;
  logic [7:0]        byte_q;
  logic [LW-1:0]     lat_cnt;
  logic              ck_phase;
  logic              accept, empty, last, fetch_done;

`ifdef STREAM_CHECKSUM_EN
  logic [7:0] checksum;
`else
  assign ck_phase = 1'b0;
`endif

  assign accept = (state == IDLE || state == DONE)
                  && start && !abort;
  assign empty  = start_addr > end_addr;
  assign last   = addr_q == end_q;
  assign fetch_done = (state == FETCH)
                      && (lat_cnt == LW'(RD_LAT - 1));

  assign busy  = state inside {FETCH, SEND, WAIT_DONE, ADVANCE};
  assign fin   = state == DONE;
  assign bus.tx_dv    = state == SEND;
  assign bus.tx_byte  = byte_q;
  assign bus.ram_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: if (accept) nxt = empty ? TAIL : FETCH;
      FETCH:      if (fetch_done) nxt = SEND;
      SEND:       nxt = WAIT_DONE;
      WAIT_DONE:  if (bus.tx_done) nxt = ck_phase ? DONE : ADVANCE;
      ADVANCE:    nxt = last ? TAIL : FETCH;
      default:    nxt = IDLE;
    endcase
    if (abort && busy) nxt = IDLE;
  end

  // byte_count counts a tx_done even when abort lands in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      end_q      <= '0;
      byte_q     <= '0;
      lat_cnt    <= '0;
      byte_count <= '0;
    end else begin
      lat_cnt <= (state == FETCH) ? lat_cnt + 1'b1 : '0;
      if (state == WAIT_DONE && bus.tx_done && !ck_phase)
        byte_count <= byte_count + 1'b1;
      if (accept) begin
        addr_q     <= start_addr;
        end_q      <= end_addr;
        byte_count <= '0;
      end
      if (fetch_done && !abort)
        byte_q <= bus.ram_q;
      if (state == ADVANCE && !last && !abort)
        addr_q <= addr_q + 1'b1;
`ifdef STREAM_CHECKSUM_EN
      if (accept && empty)
        byte_q <= 8'h00;
      if (state == ADVANCE && last && !abort)
        byte_q <= checksum;
`endif
    end
  end

`ifdef STREAM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
      ck_phase <= 1'b0;
    end else begin
      if (fetch_done && !abort)
        checksum <= checksum + bus.ram_q;
      if (state == ADVANCE && last && !abort)
        ck_phase <= 1'b1;
      if (accept) begin
        checksum <= '0;
        ck_phase <= empty;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_frame_streamer.sv
// Directed scoreboard bench for dram_frame_streamer.
// Negedge RAM model plus uart_tx responder acknowledging 20 cycles after tx_dv.
module tb_dram_frame_streamer;

  localparam int ADDR_W = 18;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              busy;
  logic              fin;
  logic [ADDR_W:0]   byte_count;
  logic              resp_done;
  logic              spur_done;

  int checks = 0;
  int errors = 0;
  int dv_count = 0;
  logic [7:0] exp_q[$];

  dram_frame_streamer_if #(.ADDR_W(ADDR_W)) bus ();

  dram_frame_streamer #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .bus       (bus.master),
    .busy      (busy),
    .fin       (fin),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    unique case (a)
      18'd10:  v = 8'h41;
      18'd11:  v = 8'h42;
      18'd12:  v = 8'h43;
      default: v = a[7:0] + 8'h33;
    endcase
    return v;
  endfunction

  always @(negedge clk) bus.ram_q <= mem(bus.ram_addr);
  assign bus.tx_done = resp_done | spur_done;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    logic [7:0] sum;
    sum = 8'h00;
    for (int a = lo; a <= hi; a++) begin
      exp_q.push_back(mem(ADDR_W'(a)));
      sum = sum + mem(ADDR_W'(a));
    end
`ifdef STREAM_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int lo, input int hi);
    start_addr = ADDR_W'(lo);
    end_addr   = ADDR_W'(hi);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fin(input string tag);
    for (int i = 0; i < 400 && !fin; i++) tick();
    check(tag, fin, 1'b1);
  endtask

  task automatic wait_dv(input string tag, input int n);
    for (int i = 0; i < 200 && dv_count < n; i++) tick();
    check(tag, dv_count >= n, 1'b1);
  endtask

  // uart_tx stand-in: scoreboard pop on tx_dv, ack 20 cycles later
  initial begin
    logic [7:0] cap;
    logic [7:0] e;
    resp_done = 1'b0;
    forever begin
      tick();
      if (bus.tx_dv === 1'b1) begin
        dv_count++;
        cap = bus.tx_byte;
        check("dv_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_byte", cap, e);
        end
        tick();
        check("dv_one_cycle", bus.tx_dv, 1'b0);
        repeat (18) tick();
        check("byte_hold", bus.tx_byte, cap);
        resp_done = 1'b1;
        tick();
        resp_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    spur_done = 1'b0;
    start_addr = '0;
    end_addr = '0;
    repeat (3) tick();
    check("rst_addr", bus.ram_addr, 0);
    check("rst_dv", bus.tx_dv, 0);
    check("rst_byte", bus.tx_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_fin", fin, 0);
    check("rst_cnt", byte_count, 0);
    rst = 1'b0;
    tick();

    // basic three-byte stream
    base = dv_count;
    push_range(10, 12);
    pulse_start(10, 12);
    check("t1_busy", busy, 1);
    check("t1_addr", bus.ram_addr, 10);
    check("t1_fin0", fin, 0);
    wait_fin("t1_fin");
    check("t1_cnt", byte_count, 3);
    check("t1_busy0", busy, 0);
    check("t1_q_empty", exp_q.size(), 0);
`ifdef STREAM_CHECKSUM_EN
    check("t1_ndv", dv_count - base, 4);
`else
    check("t1_ndv", dv_count - base, 3);
`endif
    repeat (3) tick();

    // single address
    push_range(5, 5);
    pulse_start(5, 5);
    wait_fin("t2_fin");
    check("t2_cnt", byte_count, 1);
    check("t2_q_empty", exp_q.size(), 0);

    // empty range
    base = dv_count;
    push_range(7, 6);
    pulse_start(7, 6);
`ifndef STREAM_CHECKSUM_EN
    check("t3_fin_now", fin, 1);
`endif
    wait_fin("t3_fin");
    repeat (3) tick();
    check("t3_cnt", byte_count, 0);
    check("t3_q_empty", exp_q.size(), 0);
`ifdef STREAM_CHECKSUM_EN
    check("t3_ndv", dv_count - base, 1);
`else
    check("t3_ndv", dv_count - base, 0);
`endif

    // top of address space
    push_range(262142, 262143);
    pulse_start(262142, 262143);
    wait_fin("t4_fin");
    check("t4_cnt", byte_count, 2);
    check("t4_addr", bus.ram_addr, 262143);
    check("t4_q_empty", exp_q.size(), 0);

    // abort in WAIT_DONE of second byte
    base = dv_count;
    exp_q.push_back(mem(ADDR_W'(0)));
    exp_q.push_back(mem(ADDR_W'(1)));
    pulse_start(0, 9);
    wait_dv("t5_dv2", base + 2);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_fin", fin, 0);
    check("t5_dv", bus.tx_dv, 0);
    check("t5_cnt", byte_count, 1);
    repeat (30) tick();
    check("t5_cnt_after", byte_count, 1);
    check("t5_ndv", dv_count - base, 2);
    check("t5_busy_after", busy, 0);

    // reset while in FETCH
    base = dv_count;
    pulse_start(20, 22);
    rst = 1'b1;
    tick();
    check("t6_addr", bus.ram_addr, 0);
    check("t6_byte", bus.tx_byte, 0);
    check("t6_dv", bus.tx_dv, 0);
    check("t6_busy", busy, 0);
    check("t6_fin", fin, 0);
    check("t6_cnt", byte_count, 0);
    rst = 1'b0;
    repeat (5) tick();
    check("t6_ndv", dv_count - base, 0);

    // start while busy is ignored
    base = dv_count;
    push_range(30, 32);
    pulse_start(30, 32);
    wait_dv("t7_dv1", base + 1);
    pulse_start(40, 45);
    wait_fin("t7_fin");
    check("t7_cnt", byte_count, 3);
    check("t7_addr", bus.ram_addr, 32);
    check("t7_q_empty", exp_q.size(), 0);

    // spurious tx_done during FETCH
    push_range(50, 52);
    pulse_start(50, 52);
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    check("t8_cnt0", byte_count, 0);
    wait_fin("t8_fin");
    check("t8_cnt", byte_count, 3);
    check("t8_q_empty", exp_q.size(), 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
